// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, default oversampling and the
// parity helper used by both uart_tx and uart_rx.
package uart_pkg;

    localparam int unsigned UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } rx_state_e;

    // Zero-extension to 32 bits leaves the XOR reduction unchanged.
    function automatic logic calc_parity(input logic [31:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous rx pin; resets to the idle level (1).
module uart_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_s
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: start, MSB-first data, parity, stop.
// Delivers each byte with a one-cycle rx_valid strobe and parity/framing flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned OVERSAMPLE  = UART_OVERSAMPLE,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_clk_rx,
    input  logic                 p_sel,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

    logic rx_s;

    rx_state_e              state_q, state_d;
    logic [TW-1:0]          tick_q, tick_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   par_mis_q, par_mis_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   valid_q, valid_d;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .rx   (rx),
        .rx_s (rx_s)
    );

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        par_mis_d = par_mis_q;
        data_d    = data_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        valid_d   = 1'b0;

        if (baud_clk_rx) begin
            unique case (state_q)
                StIdle: begin
                    if (!rx_s) begin
                        state_d = StStart;
                        tick_d  = '0;
                    end
                end
                StStart: begin
                    if (tick_q == HALF_LAST) begin
                        tick_d = '0;
                        if (!rx_s) begin
                            state_d = StData;
                            bit_d   = '0;
                        end else begin
                            state_d = StIdle;  // glitch shorter than half a bit
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                StData: begin
                    if (tick_q == BIT_LAST) begin
                        tick_d  = '0;
                        shreg_d = {shreg_q[DATA_BITS-2:0], rx_s};
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == DATA_LAST) begin
                            state_d = StParity;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                StParity: begin
                    if (tick_q == BIT_LAST) begin
                        tick_d    = '0;
                        par_mis_d = rx_s != calc_parity(32'(shreg_q), p_sel);
                        state_d   = StStop;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                StStop: begin
                    if (tick_q == BIT_LAST) begin
                        tick_d  = '0;
                        data_d  = shreg_q;
                        perr_d  = par_mis_q;
                        ferr_d  = ~rx_s;
                        valid_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            tick_q    <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            par_mis_q <= 1'b0;
            data_q    <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            par_mis_q <= par_mis_d;
            data_q    <= data_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            valid_q   <= valid_d;
        end
    end

    assign data_out   = data_q;
    assign rx_valid   = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Randomised scoreboard bench for uart_rx: frames are driven bit by bit and the
// expected byte/flags are queued; a monitor pops and compares on each rx_valid.
module tb_uart_rx;

    localparam int unsigned BIT_CLKS = 64;  // 16 ticks x 4 clk per tick

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       baud_clk_rx;
    logic       p_sel = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    logic [1:0] div_q = 2'd0;
    exp_t       exp_q[$];
    logic [7:0] model_data = 8'h00;
    logic       model_pe = 1'b0;
    logic       model_fe = 1'b0;
    int         n_tests = 0;
    int         n_fail = 0;

    uart_rx dut (
        .clk        (clk),
        .reset      (reset),
        .baud_clk_rx(baud_clk_rx),
        .p_sel      (p_sel),
        .rx         (rx),
        .data_out   (data_out),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) div_q <= div_q + 2'd1;
    assign baud_clk_rx = (div_q == 2'd3);

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rx_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("data_out", 32'(data_out), 32'(e.d));
                check("parity_err", 32'(parity_err), 32'(e.pe));
                check("frame_err", 32'(frame_err), 32'(e.fe));
                model_data = e.d;
                model_pe   = e.pe;
                model_fe   = e.fe;
            end
        end
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    // Drives one frame; the expected outcome is derived from the frame contents.
    task automatic send_frame(input logic [7:0] d, input logic odd, input logic par_bad,
                              input logic stop_val);
        logic par;
        exp_t e;
        par = logic'($countones(d) % 2) ^ odd;  // bit that makes the total count right
        if (par_bad) par = ~par;
        e.d  = d;
        e.pe = par_bad;
        e.fe = ~stop_val;
        exp_q.push_back(e);
        p_sel = odd;
        drive_bit(1'b0);
        for (int i = 7; i >= 0; i--) drive_bit(d[i]);
        drive_bit(par);
        drive_bit(stop_val);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_outputs_held(input string tag);
        check({tag, "_data_out"}, 32'(data_out), 32'(model_data));
        check({tag, "_parity_err"}, 32'(parity_err), 32'(model_pe));
        check({tag, "_frame_err"}, 32'(frame_err), 32'(model_fe));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       odd;
        logic       pb;
        logic       sv;

        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_data_out", 32'(data_out), 32'h0);
        check("reset_rx_valid", 32'(rx_valid), 32'h0);
        check("reset_parity_err", 32'(parity_err), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        idle(40);

        // 1: clean even-parity frame
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        idle(8);
        check("t1_busy_after", 32'(busy), 32'h0);
        idle(60);

        // 2: odd parity selected, parity bit wrong
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        idle(100);

        // 3: stop bit 0, then a clean frame clears both flags
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
        idle(BIT_CLKS);
        send_frame(8'h01, 1'b0, 1'b0, 1'b1);
        idle(100);

        // 4: short low pulse is rejected as a glitch
        rx = 1'b0;
        repeat (14) @(negedge clk);
        check("t4_busy_during", 32'(busy), 32'h1);
        repeat (2) @(negedge clk);
        idle(BIT_CLKS);
        check("t4_busy_after", 32'(busy), 32'h0);
        check_outputs_held("t4");

        // 5: back-to-back frames, no idle gap
        send_frame(8'h55, 1'b0, 1'b0, 1'b1);
        send_frame(8'hAA, 1'b1, 1'b0, 1'b1);
        idle(100);

        // 6: reset in the middle of the data bits of 0x81
        p_sel = 1'b0;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        rx    = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_data = 8'h00;
        model_pe   = 1'b0;
        model_fe   = 1'b0;
        @(negedge clk);
        check("t6_busy_after_reset", 32'(busy), 32'h0);
        check("t6_rx_valid_after_reset", 32'(rx_valid), 32'h0);
        check_outputs_held("t6");
        idle(8 * BIT_CLKS);
        check_outputs_held("t6_quiet");
        send_frame(8'h7E, 1'b0, 1'b0, 1'b1);
        idle(100);

        // Random frames with occasional parity/framing errors and random gaps
        for (int n = 0; n < 60; n++) begin
            d   = 8'($urandom);
            odd = 1'($urandom);
            pb  = ($urandom_range(0, 7) == 0);
            sv  = ($urandom_range(0, 7) != 0);
            send_frame(d, odd, pb, sv);
            // after a framing error leave a full bit of idle so the low stop is not a start
            if (!sv) idle(BIT_CLKS + 8);
            else if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 100));
        end
        idle(16);

        for (int w = 0; w < 500 && exp_q.size() != 0; w++) @(negedge clk);
        check("frames_outstanding", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
